fml_arbiter_2p: RTL

FML_ARBITER_2P -- requirements
Module: fml_arbiter_2p

---
 rtl/fml_arbiter_2p.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fml_arbiter_2p.sv
// Two-master FML burst arbiter: port 0 (video) has priority, port 1 (CPU/DMA)
// is protected from starvation by a bounded count of consecutive port-0 wins.
module fml_arbiter_2p #(
  parameter int g_fml_depth  = 26,
  parameter int g_burst_len  = 4,
  parameter int g_max_consec = 8
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_i,

  input  logic [g_fml_depth-1:0] m0_adr_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [3:0]             m0_sel_i,
  input  logic [31:0]            m0_dw_i,
  output logic [31:0]            m0_dr_o,
  output logic                   m0_ack_o,

  input  logic [g_fml_depth-1:0] m1_adr_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [3:0]             m1_sel_i,
  input  logic [31:0]            m1_dw_i,
  output logic [31:0]            m1_dr_o,
  output logic                   m1_ack_o,

  output logic [g_fml_depth-1:0] fml_adr_o,
  output logic                   fml_stb_o,
  output logic                   fml_we_o,
  output logic [3:0]             fml_sel_o,
  output logic [31:0]            fml_dw_o,
  input  logic [31:0]            fml_dr_i,
  input  logic                   fml_ack_i,

  output logic [1:0]             grant_o,
  output logic [1:0]             dbg_state_o,
  output logic [7:0]             dbg_consec_o
);

  // Handshake: a master raises mN_stb_i and holds it until mN_ack_o; the slave
  // sees fml_stb_o held until fml_ack_i, which marks the first data word.
  // The remaining g_burst_len-1 words follow on consecutive cycles.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam logic [7:0] c_max_consec = 8'(g_max_consec);
  localparam logic [4:0] c_last_beat  = 5'(g_burst_len - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic        r_stb,   w_stb_nxt;
  logic [4:0]  r_beat,  w_beat_nxt;
  logic [7:0]  r_consec, w_consec_nxt;
  logic        w_m1_forced;

  // Port 1 overrides priority once port 0 has used up its consecutive quota.
  assign w_m1_forced = m1_stb_i && (r_consec == c_max_consec);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_stb_nxt    = r_stb;
    w_beat_nxt   = r_beat;
    w_consec_nxt = r_consec;
    case (r_state)
      S_IDLE: begin
        w_stb_nxt  = 1'b0;
        w_beat_nxt = 5'd0;
        if (!m1_stb_i) w_consec_nxt = 8'd0;
        if (m0_stb_i && !w_m1_forced) begin
          w_grant_nxt = 2'b01;
          w_stb_nxt   = 1'b1;
          w_state_nxt = S_REQ;
          if (m1_stb_i && (r_consec < c_max_consec))
            w_consec_nxt = r_consec + 8'd1;
        end else if (m1_stb_i) begin
          w_grant_nxt  = 2'b10;
          w_stb_nxt    = 1'b1;
          w_state_nxt  = S_REQ;
          w_consec_nxt = 8'd0;
        end
      end
      S_REQ: begin
        if (fml_ack_i) begin
          w_stb_nxt   = 1'b0;
          w_beat_nxt  = 5'd1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (r_beat >= c_last_beat) begin
          w_beat_nxt  = 5'd0;
          w_grant_nxt = 2'b00;
          w_state_nxt = S_IDLE;
        end else begin
          w_beat_nxt = r_beat + 5'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
        w_stb_nxt   = 1'b0;
        w_beat_nxt  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= 2'b00;
      r_stb    <= 1'b0;
      r_beat   <= 5'd0;
      r_consec <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_stb    <= w_stb_nxt;
      r_beat   <= w_beat_nxt;
      r_consec <= w_consec_nxt;
    end
  end

  // Grant is non-zero exactly in REQ and BURST, so it alone gates the muxes.
  always_comb begin
    fml_adr_o = '0;
    fml_we_o  = 1'b0;
    fml_sel_o = 4'd0;
    fml_dw_o  = 32'd0;
    if (r_grant[0]) begin
      fml_adr_o = m0_adr_i;
      fml_we_o  = m0_we_i;
      fml_sel_o = m0_sel_i;
      fml_dw_o  = m0_dw_i;
    end else if (r_grant[1]) begin
      fml_adr_o = m1_adr_i;
      fml_we_o  = m1_we_i;
      fml_sel_o = m1_sel_i;
      fml_dw_o  = m1_dw_i;
    end
  end

  assign fml_stb_o    = r_stb;
  assign grant_o      = r_grant;
  assign m0_dr_o      = fml_dr_i;
  assign m1_dr_o      = fml_dr_i;
  assign m0_ack_o     = fml_ack_i && (r_state == S_REQ) && r_grant[0] && !rst_i;
  assign m1_ack_o     = fml_ack_i && (r_state == S_REQ) && r_grant[1] && !rst_i;
  assign dbg_state_o  = r_state;
  assign dbg_consec_o = r_consec;

endmodule
